// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and stall controller for a classic 5-stage in-order pipeline.
// It produces the clock enables and bubble-insert (flush) strobes for the
// pipeline registers. It handles:
//   - load-use hazards: one bubble is inserted into ID/EX and PC/IF-ID are held.
//   - taken branches: IF/ID and ID/EX are flushed.
//   - memory waits: the whole pipe is frozen until MemReady arrives.
//   - memory timeouts: a sticky error state that only Reset leaves.
//
// Optional feature (macro PIPE_HAZARD_STALL_CNT_EN):
//   When the macro is defined, StallCount counts the Ticks on which PcEn=0.
//   The count saturates at 16'hFFFF. When the macro is undefined, StallCount
//   is tied to 0 and no counter exists.
//
// Parameters
//   REG_AW   register-index width
//   TIMEOUT  memory-wait limit in Ticks (1..65535)
//
// Ports
//   Clock                   rising-edge clock
//   Reset                   asynchronous, active-high reset
//   Tick                    advance qualifier; no state change and all
//                           strobes low while 0
//   IdRs1, IdRs2            ID-stage source register indices
//   IdUsesRs1, IdUsesRs2    the corresponding source is actually read
//   ExMemRead, ExRd         EX-stage instruction is a load / its destination
//   BranchTaken             EX-stage branch resolved taken
//   MemReq, MemReady        MEM access pending / access complete
//   PcEn..MemWbEn           pipeline register clock enables
//   IfIdFlush, IdExFlush    synchronous bubble insert
//   MemTimeout              sticky memory-timeout flag
//   State                   current FSM state (RUN=00 LDUSE=01 MEMWAIT=10 ERROR=11)
//   StallCount              stalled-Tick counter (0 unless the macro is defined)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int REG_AW  = 5,
   parameter int TIMEOUT = 255
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Tick,
   input  logic [REG_AW-1:0] IdRs1,
   input  logic [REG_AW-1:0] IdRs2,
   input  logic              IdUsesRs1,
   input  logic              IdUsesRs2,
   input  logic              ExMemRead,
   input  logic [REG_AW-1:0] ExRd,
   input  logic              BranchTaken,
   input  logic              MemReq,
   input  logic              MemReady,
   output logic              PcEn,
   output logic              IfIdEn,
   output logic              IdExEn,
   output logic              ExMemEn,
   output logic              MemWbEn,
   output logic              IfIdFlush,
   output logic              IdExFlush,
   output logic              MemTimeout,
   output logic [1:0]        State,
   output logic [15:0]       StallCount
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      LDUSE   = 2'b01,
      MEMWAIT = 2'b10,
      ERROR   = 2'b11
   } state_t;

   // The wait counter tops out at TIMEOUT (<= 65535), so it fits in 16 bits.
   // The error fires on the Tick that takes the count from TIMEOUT-1 to TIMEOUT.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        timeout_q, timeout_d;

   logic mem_stall;
   logic hazard;
   logic apply_run;   // this Tick resolves with the normal RUN priority
   logic rule_ms;     // memory-stall term as seen by the RUN priority
   logic rule_hz;     // load-use term as seen by the RUN priority

   assign mem_stall = MemReq & ~MemReady;

   // A load writing x0 never creates a dependency.
   assign hazard = ExMemRead & (ExRd != '0) &
                   ((IdUsesRs1 & (IdRs1 == ExRd)) | (IdUsesRs2 & (IdRs2 == ExRd)));

   // Next state and outputs
   always_comb begin
      PcEn       = 1'b0;
      IfIdEn     = 1'b0;
      IdExEn     = 1'b0;
      ExMemEn    = 1'b0;
      MemWbEn    = 1'b0;
      IfIdFlush  = 1'b0;
      IdExFlush  = 1'b0;
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      apply_run  = 1'b0;
      rule_ms    = 1'b0;
      rule_hz    = 1'b0;

      if (Tick && !Reset) begin
         case (state_q)
            RUN: begin
               apply_run = 1'b1;
               rule_ms   = mem_stall;
               rule_hz   = hazard;
            end
            LDUSE: begin
               // The bubble for this load is already in; never stall twice.
               apply_run = 1'b1;
               rule_ms   = mem_stall;
            end
            MEMWAIT: begin
               if (MemReady) begin
                  // Completion beats a timeout on the same Tick.
                  apply_run  = 1'b1;
                  rule_hz    = hazard;
                  wait_cnt_d = '0;
               end else begin
                  wait_cnt_d = wait_cnt_q + 16'd1;
                  if (wait_cnt_q >= WAIT_LAST) begin
                     state_d   = ERROR;
                     timeout_d = 1'b1;
                  end
               end
            end
            default: begin
               // ERROR: everything frozen until Reset.
            end
         endcase

         if (apply_run) begin
            if (rule_ms) begin
               state_d = MEMWAIT;
            end else if (BranchTaken) begin
               PcEn      = 1'b1;
               IfIdEn    = 1'b1;
               IdExEn    = 1'b1;
               ExMemEn   = 1'b1;
               MemWbEn   = 1'b1;
               IfIdFlush = 1'b1;
               IdExFlush = 1'b1;
               state_d   = RUN;
            end else if (rule_hz) begin
               IdExEn    = 1'b1;
               ExMemEn   = 1'b1;
               MemWbEn   = 1'b1;
               IdExFlush = 1'b1;
               state_d   = LDUSE;
            end else begin
               PcEn    = 1'b1;
               IfIdEn  = 1'b1;
               IdExEn  = 1'b1;
               ExMemEn = 1'b1;
               MemWbEn = 1'b1;
               state_d = RUN;
            end
         end
      end
   end

   // State register; next-state logic already holds everything while Tick=0
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign State      = state_q;
   assign MemTimeout = timeout_q;

`ifdef PIPE_HAZARD_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         stall_cnt_q <= '0;
      end else if (Tick && !PcEn && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign StallCount = stall_cnt_q;
`else
   assign StallCount = 16'd0;
`endif

endmodule
